// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and coordinate type for the VGA sync generator
package vga_timing_pkg;

  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - raster timing bundle from the sync generator to pixel producers
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   ready;
  coord_t col_addr_sig;
  coord_t row_addr_sig;
  logic   frame_start;

  modport master (
    output hsync, vsync, ready, col_addr_sig, row_addr_sig, frame_start
  );

  modport slave (
    input hsync, vsync, ready, col_addr_sig, row_addr_sig, frame_start
  );

endinterface

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - wrapping raster axis counter with carry, active and sync-window flags
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = VGA_H_TOTAL,
  parameter int ACTIVE     = VGA_H_ACTIVE,
  parameter int SYNC_START = VGA_H_SYNC_START,
  parameter int SYNC_END   = VGA_H_SYNC_END
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t cnt,
  output logic   carry,
  output logic   in_active,
  output logic   in_sync
);

  logic at_last;

  assign at_last   = (cnt == coord_t'(TOTAL - 1));
  assign carry     = en && at_last;
  assign in_active = (cnt < coord_t'(ACTIVE));
  assign in_sync   = (cnt >= coord_t'(SYNC_START)) && (cnt < coord_t'(SYNC_END));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing master; VGA_SYNC_CLKDIV_EN derives the pixel tick from a 2x clk
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_gen_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic   tick;
  coord_t h_cnt, v_cnt;
  logic   h_carry, h_act, h_sync_win;
  logic   v_carry, v_act, v_sync_win;
  logic   start_pend;
  logic   visible;

`ifdef VGA_SYNC_CLKDIV_EN
  logic div_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= 1'b0;
    end else begin
      div_q <= ~div_q;
    end
  end

  assign tick = div_q;
`else
  assign tick = 1'b1;
`endif

  vga_axis_cnt #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
    .SYNC_START(H_ACTIVE + H_FP), .SYNC_END(H_ACTIVE + H_FP + H_SYNC)
  ) u_h_cnt (
    .clk(clk), .rst(rst), .en(tick), .cnt(h_cnt),
    .carry(h_carry), .in_active(h_act), .in_sync(h_sync_win)
  );

  vga_axis_cnt #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
    .SYNC_START(V_ACTIVE + V_FP), .SYNC_END(V_ACTIVE + V_FP + V_SYNC)
  ) u_v_cnt (
    .clk(clk), .rst(rst), .en(h_carry), .cnt(v_cnt),
    .carry(v_carry), .in_active(v_act), .in_sync(v_sync_win)
  );

  assign visible = h_act && v_act;

  // A frame begins on the first tick after reset or after the vertical wrap;
  // frame_start is cleared on non-tick clocks so it stays one clk wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vif.hsync        <= ~SYNC_POL;
      vif.vsync        <= ~SYNC_POL;
      vif.ready        <= 1'b0;
      vif.col_addr_sig <= '0;
      vif.row_addr_sig <= '0;
      vif.frame_start  <= 1'b0;
      start_pend       <= 1'b1;
    end else if (tick) begin
      vif.hsync        <= h_sync_win ? SYNC_POL : ~SYNC_POL;
      vif.vsync        <= v_sync_win ? SYNC_POL : ~SYNC_POL;
      vif.ready        <= visible;
      vif.col_addr_sig <= visible ? h_cnt : '0;
      vif.row_addr_sig <= visible ? v_cnt : '0;
      vif.frame_start  <= start_pend;
      start_pend       <= v_carry;
    end else begin
      vif.frame_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed self-checking bench for vga_sync_gen (full-size and reduced-size instances)
module tb_vga_sync_gen;

`ifdef VGA_SYNC_CLKDIV_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  // reduced raster: 32 ticks per line, 13 lines per frame, 416 ticks per frame
  localparam int S_HA = 16, S_HFP = 4, S_HS = 6, S_HBP = 6;
  localparam int S_VA = 6, S_VFP = 2, S_VS = 2, S_VBP = 3;
  localparam int RUN_N = 852 * DIV;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        rdy;
    logic        fs;
    logic [10:0] col;
    logic [10:0] row;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   k;

  always #5 clk = ~clk;

  vga_sync_gen_if f_if ();
  vga_sync_gen_if s_if ();

  vga_sync_gen u_full (.clk(clk), .rst(rst), .vif(f_if));

  vga_sync_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .SYNC_POL(1'b0)
  ) u_small (.clk(clk), .rst(rst), .vif(s_if));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // expected outputs k clocks after reset release (active-low sync)
  function automatic exp_t model(input int kk, input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw, input int vbp);
    exp_t e;
    int p, h, v, htot, vtot;
    htot  = ha + hfp + hsw + hbp;
    vtot  = va + vfp + vsw + vbp;
    e.hs  = 1'b1;
    e.vs  = 1'b1;
    e.rdy = 1'b0;
    e.fs  = 1'b0;
    e.col = '0;
    e.row = '0;
    if (kk < DIV) return e;
    p     = kk / DIV - 1;
    h     = p % htot;
    v     = (p / htot) % vtot;
    e.rdy = (h < ha) && (v < va);
    e.hs  = !((h >= ha + hfp) && (h < ha + hfp + hsw));
    e.vs  = !((v >= va + vfp) && (v < va + vfp + vsw));
    e.col = e.rdy ? 11'(h) : 11'd0;
    e.row = e.rdy ? 11'(v) : 11'd0;
    e.fs  = (p % (htot * vtot) == 0) && (kk % DIV == 0);
    return e;
  endfunction

  task automatic check_full(input exp_t e);
    check($sformatf("full_hsync k=%0d", k), 32'(f_if.hsync), 32'(e.hs));
    check($sformatf("full_vsync k=%0d", k), 32'(f_if.vsync), 32'(e.vs));
    check($sformatf("full_ready k=%0d", k), 32'(f_if.ready), 32'(e.rdy));
    check($sformatf("full_fs k=%0d", k), 32'(f_if.frame_start), 32'(e.fs));
    check($sformatf("full_col k=%0d", k), 32'(f_if.col_addr_sig), 32'(e.col));
    check($sformatf("full_row k=%0d", k), 32'(f_if.row_addr_sig), 32'(e.row));
  endtask

  task automatic check_small(input exp_t e);
    check($sformatf("small_hsync k=%0d", k), 32'(s_if.hsync), 32'(e.hs));
    check($sformatf("small_vsync k=%0d", k), 32'(s_if.vsync), 32'(e.vs));
    check($sformatf("small_ready k=%0d", k), 32'(s_if.ready), 32'(e.rdy));
    check($sformatf("small_fs k=%0d", k), 32'(s_if.frame_start), 32'(e.fs));
    check($sformatf("small_col k=%0d", k), 32'(s_if.col_addr_sig), 32'(e.col));
    check($sformatf("small_row k=%0d", k), 32'(s_if.row_addr_sig), 32'(e.row));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  int   f_rdy_n = 0, f_hs_n = 0, f_hs_first = -1, f_rise0 = -1, f_rise1 = -1;
  int   s_fs_n = 0, s_fs0 = -1, s_fs1 = -1, s_vs_n = 0;
  logic f_prev_rdy = 1'b0;
  exp_t rst_e;

  initial begin
    rst_e = '{hs: 1'b1, vs: 1'b1, rdy: 1'b0, fs: 1'b0, col: 11'd0, row: 11'd0};

    // reset held for 5 clocks
    k = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_full(rst_e);
    check_small(rst_e);

    // release and run two reduced frames / two full lines
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < RUN_N; i++) begin
      step();
      check_full(model(k, 640, 16, 96, 48, 480, 10, 2, 33));
      check_small(model(k, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP));
      if (k == DIV) begin
        check("first_tick_ready", 32'(f_if.ready), 32'd1);
        check("first_tick_fs", 32'(f_if.frame_start), 32'd1);
      end
      // last visible pixel (15,5) then blanking
      if (k == 176 * DIV) begin
        check("last_vis_col", 32'(s_if.col_addr_sig), 32'd15);
        check("last_vis_row", 32'(s_if.row_addr_sig), 32'd5);
        check("last_vis_ready", 32'(s_if.ready), 32'd1);
      end
      if (k == 177 * DIV) check("after_last_vis_ready", 32'(s_if.ready), 32'd0);
      if (k == 417 * DIV) begin
        check("wrap_fs", 32'(s_if.frame_start), 32'd1);
        check("wrap_ready", 32'(s_if.ready), 32'd1);
      end
      if (k <= 800 * DIV) begin
        if (f_if.ready) f_rdy_n++;
        if (!f_if.hsync) begin
          f_hs_n++;
          if (f_hs_first < 0) f_hs_first = k;
        end
      end
      if (f_if.ready && !f_prev_rdy) begin
        if (f_rise0 < 0) f_rise0 = k;
        else if (f_rise1 < 0) f_rise1 = k;
      end
      f_prev_rdy = f_if.ready;
      if (s_if.frame_start) begin
        s_fs_n++;
        if (s_fs0 < 0) s_fs0 = k;
        else if (s_fs1 < 0) s_fs1 = k;
      end
      if (k <= 416 * DIV && !s_if.vsync) s_vs_n++;
    end

    check("full_ready_cycles_line0", 32'(f_rdy_n), 32'(640 * DIV));
    check("full_hsync_low_cycles", 32'(f_hs_n), 32'(96 * DIV));
    check("full_hsync_offset", 32'(f_hs_first - f_rise0), 32'(656 * DIV));
    check("full_line_period", 32'(f_rise1 - f_rise0), 32'(800 * DIV));
    check("small_frame_period", 32'(s_fs1 - s_fs0), 32'(416 * DIV));
    check("small_fs_pulses", 32'(s_fs_n), 32'd3);
    check("small_vsync_low_cycles", 32'(s_vs_n), 32'(64 * DIV));

    // mid-frame reset at pixel (10,5) of the reduced raster
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (k < 171 * DIV) step();
    check("pre_reset_col", 32'(s_if.col_addr_sig), 32'd10);
    check("pre_reset_row", 32'(s_if.row_addr_sig), 32'd5);
    rst = 1'b1;
    #1;
    check_small(rst_e);
    check_full(rst_e);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 40 * DIV; i++) begin
      step();
      check_small(model(k, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP));
      check_full(model(k, 640, 16, 96, 48, 480, 10, 2, 33));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
